// File: rtl/clk_div_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_pkg                                                          |
// | Shared state encoding and constants for the clock divider control.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_WIDTH = 8;

endpackage
`default_nettype wire

// File: rtl/div_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | div_counter                                                          |
// | Period counter with wrap detect and high/low phase compare.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module div_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_run,
    input  logic [WIDTH-1:0] i_div,
    output logic             o_wrap,
    output logic             o_clk_out,
    output logic             o_tick
);

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_half;
    logic             w_wrap;
    logic             r_clk_out;
    logic             r_tick;

    always_comb begin
        w_half    = i_div >> 1;
        w_wrap    = (r_cnt == (i_div - WIDTH'(1)));
        w_cnt_nxt = w_wrap ? '0 : (r_cnt + WIDTH'(1));
    end

    // Output phase is derived from the post-edge count so clk_out and tick
    // line up with the count value they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else if (i_start) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b1;
            r_tick    <= 1'b1;
        end else if (i_run) begin
            r_cnt     <= w_cnt_nxt;
            r_clk_out <= (w_cnt_nxt < w_half);
            r_tick    <= (w_cnt_nxt == '0);
        end else begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end
    end

    assign o_wrap    = w_wrap;
    assign o_clk_out = r_clk_out;
    assign o_tick    = r_tick;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | clk_div_ctrl                                                         |
// | Programmable clock divider with glitch-free ratio change handshake.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             cl,
    input  logic             rst,
    input  logic             en,
    input  logic             div_req,
    input  logic [WIDTH-1:0] div_val,
    output logic             clk_out,
    output logic             tick,
    output logic             div_ack,
    output logic             div_err,
    output logic             busy
);

    localparam logic [WIDTH-1:0] c_min_div     = WIDTH'(MIN_DIV);
    localparam logic [WIDTH-1:0] c_default_div = WIDTH'(DEFAULT_DIV);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_div;
    logic [WIDTH-1:0] w_div_nxt;
    logic [WIDTH-1:0] r_pend_div;
    logic [WIDTH-1:0] w_pend_div_nxt;
    logic             r_div_ack;
    logic             w_div_ack_nxt;
    logic             r_div_err;
    logic             r_busy;
    logic             w_req_ok;
    logic             w_req_bad;
    logic             w_wrap;
    logic             w_start;
    logic             w_run;

    assign w_req_ok  = div_req && (div_val >= c_min_div);
    assign w_req_bad = div_req && (div_val <  c_min_div);
    assign w_start   = (r_state == IDLE) && en;
    assign w_run     = (r_state != IDLE) && en;

    always_ff @(posedge cl) begin
        if (rst) begin
            r_state    <= IDLE;
            r_div      <= c_default_div;
            r_pend_div <= c_default_div;
            r_div_ack  <= 1'b0;
            r_div_err  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_div      <= w_div_nxt;
            r_pend_div <= w_pend_div_nxt;
            r_div_ack  <= w_div_ack_nxt;
            r_div_err  <= w_req_bad;
            r_busy     <= (w_state_nxt == PEND);
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_div_nxt      = r_div;
        w_pend_div_nxt = r_pend_div;
        w_div_ack_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req_ok) begin
                    w_div_nxt     = div_val;
                    w_div_ack_nxt = 1'b1;
                end
                if (en) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    w_state_nxt = IDLE;
                    if (w_req_ok) begin
                        w_div_nxt     = div_val;
                        w_div_ack_nxt = 1'b1;
                    end
                end else if (w_req_ok) begin
                    w_pend_div_nxt = div_val;
                    w_state_nxt    = PEND;
                end
            end
            PEND: begin
                if (!en) begin
                    // A same-edge request is an idle load and supersedes the pending ratio.
                    w_state_nxt   = IDLE;
                    w_div_ack_nxt = 1'b1;
                    w_div_nxt     = w_req_ok ? div_val : r_pend_div;
                end else if (w_wrap) begin
                    // Request landing on the wrap edge waits for the next wrap.
                    w_div_nxt     = r_pend_div;
                    w_div_ack_nxt = 1'b1;
                    if (w_req_ok) begin
                        w_pend_div_nxt = div_val;
                        w_state_nxt    = PEND;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end else if (w_req_ok) begin
                    w_pend_div_nxt = div_val;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    div_counter #(
        .WIDTH (WIDTH)
    ) u_div_counter (
        .clk       (cl),
        .rst       (rst),
        .i_start   (w_start),
        .i_run     (w_run),
        .i_div     (r_div),
        .o_wrap    (w_wrap),
        .o_clk_out (clk_out),
        .o_tick    (tick)
    );

    assign div_ack = r_div_ack;
    assign div_err = r_div_err;
    assign busy    = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_clk_div_ctrl                                                      |
// | Scoreboard bench: reference model predicts outputs, monitor compares.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_clk_div_ctrl;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 2;

    logic             cl;
    logic             rst;
    logic             en;
    logic             div_req;
    logic [WIDTH-1:0] div_val;
    logic             clk_out;
    logic             tick;
    logic             div_ack;
    logic             div_err;
    logic             busy;

    clk_div_ctrl #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .cl      (cl),
        .rst     (rst),
        .en      (en),
        .div_req (div_req),
        .div_val (div_val),
        .clk_out (clk_out),
        .tick    (tick),
        .div_ack (div_ack),
        .div_err (div_err),
        .busy    (busy)
    );

    initial cl = 1'b0;
    always #5 cl = ~cl;

    logic [4:0] exp_q[$];
    int         n_checks = 0;
    int         n_pass   = 0;
    int         cyc      = 0;
    bit         stim_done = 1'b0;

    // Reference model: position within the output period plus the ratio bookkeeping.
    bit running = 0;
    bit pending = 0;
    int n_div   = DEFAULT_DIV;
    int pend    = DEFAULT_DIV;
    int pos     = 0;

    task automatic model_step(input bit r, input bit e, input bit rq, input int v);
        bit ok, bad, ack, wrap;
        logic [4:0] exp_v;
        ok  = rq && (v >= 2);
        bad = rq && (v < 2);
        ack = 0;
        if (r) begin
            running = 0; pending = 0; n_div = DEFAULT_DIV; pend = DEFAULT_DIV; pos = 0;
            bad = 0;
        end else if (!running) begin
            if (ok) begin n_div = v; ack = 1; end
            if (e) begin running = 1; pos = 0; end
        end else if (!e) begin
            if (pending) begin n_div = pend; ack = 1; end
            if (ok) begin n_div = v; ack = 1; end
            running = 0; pending = 0; pos = 0;
        end else begin
            wrap = (pos == n_div - 1);
            pos  = wrap ? 0 : pos + 1;
            if (wrap && pending) begin n_div = pend; ack = 1; pending = 0; end
            if (ok) begin pend = v; pending = 1; end
        end
        exp_v[4] = running && (pos < n_div / 2);
        exp_v[3] = running && (pos == 0);
        exp_v[2] = ack;
        exp_v[1] = bad;
        exp_v[0] = pending;
        exp_q.push_back(exp_v);
    endtask

    task automatic drive(input bit r, input bit e, input bit rq, input int v);
        rst = r; en = e; div_req = rq; div_val = WIDTH'(v);
        model_step(r, e, rq, v);
        @(negedge cl);
    endtask

    task automatic run_idle(input int k, input bit e);
        for (int i = 0; i < k; i++) drive(0, e, 0, 0);
    endtask

    // Monitor: one prediction per rising edge, compared just after the edge.
    initial begin
        logic [4:0] got, want;
        forever begin
            @(posedge cl);
            #1;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {clk_out, tick, div_ack, div_err, busy};
                n_checks++;
                if (got === want) n_pass++;
                else $display("FAIL outputs cycle %0d {clk_out,tick,div_ack,div_err,busy}: got %b expected %b",
                              cyc, got, want);
                cyc++;
            end
        end
    end

    initial begin
        rst = 1; en = 0; div_req = 0; div_val = '0;
        // Reset then default divide-by-two.
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        run_idle(2, 0);
        run_idle(8, 1);
        // Idle load of 5, then run.
        run_idle(2, 0);
        drive(0, 0, 1, 5);
        run_idle(16, 1);
        // Switch to 4 via en-fall load, then mid-period change to 6.
        drive(0, 0, 1, 4);
        run_idle(2, 1);
        drive(0, 1, 1, 6);
        run_idle(20, 1);
        // Back to 4, then two requests before the wrap: last one wins.
        drive(0, 0, 1, 4);
        run_idle(2, 1);
        drive(0, 1, 1, 3);
        drive(0, 1, 1, 7);
        run_idle(20, 1);
        // Illegal requests in run and idle.
        drive(0, 1, 1, 1);
        run_idle(4, 1);
        drive(0, 1, 1, 0);
        run_idle(3, 1);
        drive(0, 0, 1, 1);
        // Pending change killed by reset.
        run_idle(2, 1);
        drive(0, 1, 1, 9);
        run_idle(1, 1);
        drive(1, 1, 0, 0);
        run_idle(6, 1);
        // Pending change applied at en-fall.
        drive(0, 1, 1, 5);
        drive(0, 0, 0, 0);
        run_idle(12, 1);
        // Largest legal ratio for one period.
        drive(0, 0, 1, 255);
        run_idle(260, 1);
        drive(0, 0, 1, 3);
        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, rq;
            int v;
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 19) != 0);
            rq = ($urandom_range(0, 7) == 0);
            v  = $urandom_range(0, 9);
            drive(r, e, rq, v);
        end
        stim_done = 1'b1;
        @(negedge cl);
        @(negedge cl);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL scoreboard drain: got %0d entries left, expected 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
